// File: rtl/arc4_pkg.sv
// Shared definitions for the ARC4 stream decryptor: FSM state encoding, S-box size,
// per-stage cycle counts and the PRGA sub-step phase codes.
package arc4_pkg;

    localparam int S_SIZE               = 256;
    localparam int INIT_CYCLES          = 256;
    localparam int KSA_CYCLES_PER_ITER  = 5;
    localparam int PRGA_CYCLES_PER_BYTE = 6;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'd0,
        ST_INIT   = 5'd1,
        ST_KSA_A  = 5'd2,
        ST_KSA_B  = 5'd3,
        ST_KSA_C  = 5'd4,
        ST_KSA_D  = 5'd5,
        ST_KSA_E  = 5'd6,
        ST_DROP   = 5'd7,
        ST_LEN_A  = 5'd8,
        ST_LEN_B  = 5'd9,
        ST_PRGA_A = 5'd10,
        ST_PRGA_B = 5'd11,
        ST_PRGA_C = 5'd12,
        ST_PRGA_D = 5'd13,
        ST_PRGA_E = 5'd14,
        ST_PRGA_F = 5'd15
    } arc4_state_e;

    localparam logic [2:0] PH_A = 3'd0;
    localparam logic [2:0] PH_B = 3'd1;
    localparam logic [2:0] PH_C = 3'd2;
    localparam logic [2:0] PH_D = 3'd3;
    localparam logic [2:0] PH_E = 3'd4;
    localparam logic [2:0] PH_F = 3'd5;

    function automatic logic [2:0] prga_phase(input arc4_state_e st);
        case (st)
            ST_PRGA_A: prga_phase = PH_A;
            ST_PRGA_B: prga_phase = PH_B;
            ST_PRGA_C: prga_phase = PH_C;
            ST_PRGA_D: prga_phase = PH_D;
            ST_PRGA_E: prga_phase = PH_E;
            ST_PRGA_F: prga_phase = PH_F;
            default:   prga_phase = PH_A;
        endcase
    endfunction

endpackage

// File: rtl/arc4_prga_step.sv
// One RC4 PRGA step spread over six phases on a single-port S memory with 1-cycle read latency.
// Holds the PRGA i/j indices; used both for drop-n discards and for real keystream bytes.
module arc4_prga_step
    import arc4_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_i,
    input  logic       active_i,
    input  logic [2:0] phase_i,
    input  logic [7:0] s_rddata_i,
    output logic [7:0] s_addr_o,
    output logic [7:0] s_wrdata_o,
    output logic       s_wren_o,
    output logic [7:0] pad_o
);

    logic [7:0] i_q, i_d;
    logic [7:0] j_q, j_d;
    logic [7:0] si_q, si_d;
    logic [7:0] sj_q, sj_d;

    always_comb begin
        i_d        = i_q;
        j_d        = j_q;
        si_d       = si_q;
        sj_d       = sj_q;
        s_addr_o   = 8'd0;
        s_wrdata_o = 8'd0;
        s_wren_o   = 1'b0;
        pad_o      = 8'd0;
        if (clear_i) begin
            i_d = 8'd0;
            j_d = 8'd0;
        end else if (active_i) begin
            // A: fetch S[i+1]; B: fetch S[j]; C/D: swap; E: fetch pad; F: pad on read data
            case (phase_i)
                PH_A: begin
                    i_d      = i_q + 8'd1;
                    s_addr_o = i_d;
                end
                PH_B: begin
                    si_d     = s_rddata_i;
                    j_d      = j_q + s_rddata_i;
                    s_addr_o = j_d;
                end
                PH_C: begin
                    sj_d       = s_rddata_i;
                    s_addr_o   = i_q;
                    s_wrdata_o = s_rddata_i;
                    s_wren_o   = 1'b1;
                end
                PH_D: begin
                    s_addr_o   = j_q;
                    s_wrdata_o = si_q;
                    s_wren_o   = 1'b1;
                end
                PH_E: begin
                    s_addr_o = si_q + sj_q;
                end
                PH_F: begin
                    pad_o = s_rddata_i;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_q  <= 8'd0;
            j_q  <= 8'd0;
            si_q <= 8'd0;
            sj_q <= 8'd0;
        end else begin
            i_q  <= i_d;
            j_q  <= j_d;
            si_q <= si_d;
            sj_q <= sj_d;
        end
    end

endmodule

// File: rtl/arc4_stream.sv
// ARC4 (RC4-drop[n]) decryptor: fills S, runs KSA, discards DROP_N bytes, then
// decrypts a length-prefixed ciphertext buffer into plaintext memory.
// IDLE wait | INIT S[i]=i | KSA_A..E key schedule | DROP discard | LEN_A/B length | PRGA_A..F decrypt
module arc4_stream
    import arc4_pkg::*;
#(
    parameter int KEY_BYTES = 3,
    parameter int DROP_N    = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic                   rdy,
    input  logic                   abort,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             s_addr,
    output logic [7:0]             s_wrdata,
    output logic                   s_wren,
    input  logic [7:0]             s_rddata,
    output logic [7:0]             ct_addr,
    input  logic [7:0]             ct_rddata,
    output logic [7:0]             pt_addr,
    output logic [7:0]             pt_wrdata,
    output logic                   pt_wren
);

    localparam logic [10:0] DROP_LAST = (DROP_N > 0) ? 11'(DROP_N - 1) : 11'd0;
    localparam logic [4:0]  KIDX_LAST = 5'(KEY_BYTES - 1);

    arc4_state_e            state_q, state_d;
    logic [8*KEY_BYTES-1:0] key_q, key_d;
    logic [7:0]             i_q, i_d;
    logic [7:0]             j_q, j_d;
    logic [7:0]             si_q, si_d;
    logic [7:0]             sj_q, sj_d;
    logic [7:0]             k_q, k_d;
    logic [7:0]             len_q, len_d;
    logic [4:0]             kidx_q, kidx_d;
    logic [10:0]            drop_cnt_q, drop_cnt_d;
    logic [2:0]             drop_ph_q, drop_ph_d;

    logic [7:0] key_byte;
    logic [7:0] ksa_j;
    logic       step_clear;
    logic       step_active;
    logic       in_prga;
    logic [2:0] step_phase;
    logic [7:0] step_addr;
    logic [7:0] step_wrdata;
    logic       step_wren;
    logic [7:0] step_pad;

    always_comb begin
        key_byte = 8'd0;
        for (int b = 0; b < KEY_BYTES; b++) begin
            if (kidx_q == 5'(b)) begin
                key_byte = key_q[8*(KEY_BYTES-1-b) +: 8];
            end
        end
    end

    assign ksa_j       = j_q + s_rddata + key_byte;
    assign in_prga     = state_q inside {ST_PRGA_A, ST_PRGA_B, ST_PRGA_C,
                                         ST_PRGA_D, ST_PRGA_E, ST_PRGA_F};
    assign step_active = in_prga || (state_q == ST_DROP);
    assign step_clear  = state_q inside {ST_IDLE, ST_INIT, ST_KSA_A, ST_KSA_B,
                                         ST_KSA_C, ST_KSA_D, ST_KSA_E};
    assign step_phase  = (state_q == ST_DROP) ? drop_ph_q : prga_phase(state_q);

    arc4_prga_step u_step (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (step_clear),
        .active_i   (step_active),
        .phase_i    (step_phase),
        .s_rddata_i (s_rddata),
        .s_addr_o   (step_addr),
        .s_wrdata_o (step_wrdata),
        .s_wren_o   (step_wren),
        .pad_o      (step_pad)
    );

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        i_d        = i_q;
        j_d        = j_q;
        si_d       = si_q;
        sj_d       = sj_q;
        k_d        = k_q;
        len_d      = len_q;
        kidx_d     = kidx_q;
        drop_cnt_d = drop_cnt_q;
        drop_ph_d  = drop_ph_q;
        case (state_q)
            ST_IDLE: begin
                if (en && !abort) begin
                    key_d   = key;
                    i_d     = 8'd0;
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                i_d = i_q + 8'd1;
                if (i_q == 8'(INIT_CYCLES - 1)) begin
                    j_d     = 8'd0;
                    kidx_d  = 5'd0;
                    state_d = ST_KSA_A;
                end
            end
            ST_KSA_A: state_d = ST_KSA_B;
            ST_KSA_B: begin
                si_d    = s_rddata;
                j_d     = ksa_j;
                state_d = ST_KSA_C;
            end
            ST_KSA_C: begin
                sj_d    = s_rddata;
                state_d = ST_KSA_D;
            end
            ST_KSA_D: state_d = ST_KSA_E;
            ST_KSA_E: begin
                i_d    = i_q + 8'd1;
                kidx_d = (kidx_q == KIDX_LAST) ? 5'd0 : kidx_q + 5'd1;
                if (i_q != 8'(S_SIZE - 1)) begin
                    state_d = ST_KSA_A;
                end else if (DROP_N > 0) begin
                    drop_cnt_d = DROP_LAST;
                    drop_ph_d  = 3'd0;
                    state_d    = ST_DROP;
                end else begin
                    state_d = ST_LEN_A;
                end
            end
            ST_DROP: begin
                if (drop_ph_q == 3'(PRGA_CYCLES_PER_BYTE - 1)) begin
                    drop_ph_d = 3'd0;
                    if (drop_cnt_q == 11'd0) begin
                        state_d = ST_LEN_A;
                    end else begin
                        drop_cnt_d = drop_cnt_q - 11'd1;
                    end
                end else begin
                    drop_ph_d = drop_ph_q + 3'd1;
                end
            end
            ST_LEN_A: state_d = ST_LEN_B;
            ST_LEN_B: begin
                len_d   = ct_rddata;
                k_d     = 8'd1;
                state_d = (ct_rddata == 8'd0) ? ST_IDLE : ST_PRGA_A;
            end
            ST_PRGA_A: state_d = ST_PRGA_B;
            ST_PRGA_B: state_d = ST_PRGA_C;
            ST_PRGA_C: state_d = ST_PRGA_D;
            ST_PRGA_D: state_d = ST_PRGA_E;
            ST_PRGA_E: state_d = ST_PRGA_F;
            ST_PRGA_F: begin
                // k stops at L, so L=255 ends on k=255 without wrapping
                if (k_q == len_q) begin
                    state_d = ST_IDLE;
                end else begin
                    k_d     = k_q + 8'd1;
                    state_d = ST_PRGA_A;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end
    end

    always_comb begin
        rdy       = (state_q == ST_IDLE);
        s_addr    = 8'd0;
        s_wrdata  = 8'd0;
        s_wren    = 1'b0;
        ct_addr   = 8'd0;
        pt_addr   = 8'd0;
        pt_wrdata = 8'd0;
        pt_wren   = 1'b0;
        if (step_active) begin
            s_addr   = step_addr;
            s_wrdata = step_wrdata;
            s_wren   = step_wren;
        end
        if (in_prga) begin
            ct_addr = k_q;
        end
        case (state_q)
            ST_INIT: begin
                s_addr   = i_q;
                s_wrdata = i_q;
                s_wren   = 1'b1;
            end
            ST_KSA_A: s_addr = i_q;
            ST_KSA_B: s_addr = ksa_j;
            ST_KSA_D: begin
                s_addr   = i_q;
                s_wrdata = sj_q;
                s_wren   = 1'b1;
            end
            ST_KSA_E: begin
                s_addr   = j_q;
                s_wrdata = si_q;
                s_wren   = 1'b1;
            end
            ST_LEN_B: begin
                pt_addr   = 8'd0;
                pt_wrdata = ct_rddata;
                pt_wren   = 1'b1;
            end
            ST_PRGA_F: begin
                pt_addr   = k_q;
                pt_wrdata = step_pad ^ ct_rddata;
                pt_wren   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            key_q      <= '0;
            i_q        <= 8'd0;
            j_q        <= 8'd0;
            si_q       <= 8'd0;
            sj_q       <= 8'd0;
            k_q        <= 8'd0;
            len_q      <= 8'd0;
            kidx_q     <= 5'd0;
            drop_cnt_q <= 11'd0;
            drop_ph_q  <= 3'd0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            i_q        <= i_d;
            j_q        <= j_d;
            si_q       <= si_d;
            sj_q       <= sj_d;
            k_q        <= k_d;
            len_q      <= len_d;
            kidx_q     <= kidx_d;
            drop_cnt_q <= drop_cnt_d;
            drop_ph_q  <= drop_ph_d;
        end
    end

endmodule

// File: tb/tb_arc4_stream.sv
// Bench for arc4_stream: three instances (3-byte key, 4-byte key, 3-byte key with drop768)
// with behavioural memories, a software RC4 reference model and known-answer vectors.
module tb_arc4_stream;

    localparam int RUN_LIMIT = 8000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        en       [3];
    logic        abort    [3];
    logic [31:0] key_v    [3];
    logic        rdy      [3];
    logic [7:0]  s_addr   [3];
    logic [7:0]  s_wrdata [3];
    logic        s_wren   [3];
    logic [7:0]  s_rd     [3];
    logic [7:0]  ct_addr  [3];
    logic [7:0]  ct_rd    [3];
    logic [7:0]  pt_addr  [3];
    logic [7:0]  pt_wrdata[3];
    logic        pt_wren  [3];

    logic [7:0] s_mem  [3][256];
    logic [7:0] ct_src [3][256];
    logic [7:0] pt_mem [3][256];
    int         pt_tag [3][256];
    int         pt_cnt [3];
    int         s_cnt  [3];
    int         run_id [3];

    int checks   = 0;
    int failures = 0;

    arc4_stream #(.KEY_BYTES(3), .DROP_N(0)) dut0 (
        .clk(clk), .rst(rst), .en(en[0]), .rdy(rdy[0]), .abort(abort[0]), .key(key_v[0][23:0]),
        .s_addr(s_addr[0]), .s_wrdata(s_wrdata[0]), .s_wren(s_wren[0]), .s_rddata(s_rd[0]),
        .ct_addr(ct_addr[0]), .ct_rddata(ct_rd[0]),
        .pt_addr(pt_addr[0]), .pt_wrdata(pt_wrdata[0]), .pt_wren(pt_wren[0]));

    arc4_stream #(.KEY_BYTES(4), .DROP_N(0)) dut1 (
        .clk(clk), .rst(rst), .en(en[1]), .rdy(rdy[1]), .abort(abort[1]), .key(key_v[1]),
        .s_addr(s_addr[1]), .s_wrdata(s_wrdata[1]), .s_wren(s_wren[1]), .s_rddata(s_rd[1]),
        .ct_addr(ct_addr[1]), .ct_rddata(ct_rd[1]),
        .pt_addr(pt_addr[1]), .pt_wrdata(pt_wrdata[1]), .pt_wren(pt_wren[1]));

    arc4_stream #(.KEY_BYTES(3), .DROP_N(768)) dut2 (
        .clk(clk), .rst(rst), .en(en[2]), .rdy(rdy[2]), .abort(abort[2]), .key(key_v[2][23:0]),
        .s_addr(s_addr[2]), .s_wrdata(s_wrdata[2]), .s_wren(s_wren[2]), .s_rddata(s_rd[2]),
        .ct_addr(ct_addr[2]), .ct_rddata(ct_rd[2]),
        .pt_addr(pt_addr[2]), .pt_wrdata(pt_wrdata[2]), .pt_wren(pt_wren[2]));

    // Synchronous-read memories; each pt write is stamped with the current run number
    always @(posedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (s_wren[g]) begin
                s_mem[g][s_addr[g]] <= s_wrdata[g];
                s_cnt[g]            <= s_cnt[g] + 1;
            end
            s_rd[g]  <= s_mem[g][s_addr[g]];
            ct_rd[g] <= ct_src[g][ct_addr[g]];
            if (pt_wren[g]) begin
                pt_mem[g][pt_addr[g]] <= pt_wrdata[g];
                pt_tag[g][pt_addr[g]] <= run_id[g];
                pt_cnt[g]             <= pt_cnt[g] + 1;
            end
        end
    end

    typedef struct {
        int           inst;
        logic [31:0]  key;
        int           n;
        logic [127:0] ct;
        logic [127:0] pt;
        int           lat;
    } vec_t;

    vec_t       vecs [3];
    logic [7:0] ct_buf  [256];
    logic [7:0] exp_buf [256];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Plain software RC4-drop[n] over the length-prefixed buffer in ct_buf
    task automatic ref_model(input logic [31:0] k, input int kb, input int drop, input int n);
        int s [256];
        int kbytes [32];
        int i, j, t;
        for (int b = 0; b < kb; b++) kbytes[b] = int'((k >> (8 * (kb - 1 - b))) & 32'hFF);
        for (int x = 0; x < 256; x++) s[x] = x;
        j = 0;
        for (int x = 0; x < 256; x++) begin
            j = (j + s[x] + kbytes[x % kb]) % 256;
            t = s[x]; s[x] = s[j]; s[j] = t;
        end
        i = 0;
        j = 0;
        exp_buf[0] = ct_buf[0];
        for (int d = 0; d < drop + n - 1; d++) begin
            i = (i + 1) % 256;
            j = (j + s[i]) % 256;
            t = s[i]; s[i] = s[j]; s[j] = t;
            if (d >= drop) exp_buf[d - drop + 1] = ct_buf[d - drop + 1] ^ 8'(s[(s[i] + s[j]) % 256]);
        end
    endtask

    task automatic load_vec(input int idx);
        for (int b = 0; b < vecs[idx].n; b++) begin
            ct_buf[b]  = vecs[idx].ct[127 - 8*b -: 8];
            exp_buf[b] = vecs[idx].pt[127 - 8*b -: 8];
        end
    endtask

    task automatic run_check(input int inst, input logic [31:0] k, input int n,
                             input int exp_lat, input bit hold_en);
        int lat;
        int cnt0;
        run_id[inst] = run_id[inst] + 1;
        for (int b = 0; b < n; b++) ct_src[inst][b] = ct_buf[b];
        cnt0 = pt_cnt[inst];
        @(negedge clk);
        key_v[inst] = k;
        en[inst]    = 1'b1;
        @(negedge clk);
        if (!hold_en) en[inst] = 1'b0;
        chk("rdy_low_after_en", int'(rdy[inst]), 0);
        lat = 0;
        while (rdy[inst] !== 1'b1 && lat < RUN_LIMIT) begin
            @(negedge clk);
            lat++;
        end
        en[inst] = 1'b0;
        chk("run_latency", lat, exp_lat);
        chk("pt_write_count", pt_cnt[inst] - cnt0, n);
        for (int b = 0; b < n; b++) begin
            chk($sformatf("pt_byte[%0d]", b),
                (pt_tag[inst][b] == run_id[inst]) ? int'(pt_mem[inst][b]) : 32'h100,
                int'(exp_buf[b]));
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt0, scnt0, m, len;
        logic [31:0] rk;

        vecs[0] = '{0, 32'h004B6579, 10, 128'h09BBF316E8D940AF0AD3_000000000000,
                    128'h09506C61696E74657874_000000000000, 1538 + 54};
        vecs[1] = '{1, 32'h57696B69, 6, 128'h051021BF0420_00000000000000000000,
                    128'h057065646961_00000000000000000000, 1538 + 30};
        vecs[2] = '{0, 32'h004B6579, 1, 128'h00BBF316E8D940AF0AD3_000000000000,
                    128'h0, 1538};

        rst = 1'b1;
        for (int g = 0; g < 3; g++) begin
            en[g]     = 1'b0;
            abort[g]  = 1'b0;
            key_v[g]  = 32'h0;
            run_id[g] = 0;
        end
        repeat (3) @(negedge clk);
        chk("reset_rdy", int'(rdy[0]), 1);
        chk("reset_s_wren", int'(s_wren[0]), 0);
        chk("reset_pt_wren", int'(pt_wren[0]), 0);
        chk("reset_s_addr", int'(s_addr[0]), 0);
        chk("reset_ct_addr", int'(ct_addr[0]), 0);
        chk("reset_pt_addr", int'(pt_addr[0]) | int'(pt_wrdata[0]) | int'(s_wrdata[0]), 0);
        chk("reset_rdy_drop", int'(rdy[2]), 1);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 3; v++) begin
            load_vec(v);
            run_check(vecs[v].inst, vecs[v].key, vecs[v].n, vecs[v].lat, 1'b0);
        end

        // abort in IDLE, and en together with abort, must not start a run
        scnt0 = s_cnt[0];
        en[0]    = 1'b1;
        abort[0] = 1'b1;
        @(negedge clk);
        en[0] = 1'b0;
        chk("en_with_abort_rdy", int'(rdy[0]), 1);
        @(negedge clk);
        abort[0] = 1'b0;
        chk("abort_idle_rdy", int'(rdy[0]), 1);
        chk("abort_idle_no_s_write", s_cnt[0] - scnt0, 0);

        // abort 10 cycles into PRGA (PRGA_E of byte 2)
        load_vec(0);
        run_id[0] = run_id[0] + 1;
        for (int b = 0; b < 10; b++) ct_src[0][b] = ct_buf[b];
        cnt0 = pt_cnt[0];
        key_v[0] = vecs[0].key;
        en[0]    = 1'b1;
        @(negedge clk);
        en[0] = 1'b0;
        m = 0;
        while (m < 1548 && rdy[0] !== 1'b1) begin
            @(negedge clk);
            m++;
        end
        abort[0] = 1'b1;
        @(negedge clk);
        abort[0] = 1'b0;
        chk("abort_rdy_next", int'(rdy[0]), 1);
        chk("abort_pt_writes", pt_cnt[0] - cnt0, 2);
        scnt0 = s_cnt[0];
        repeat (20) @(negedge clk);
        chk("abort_no_more_pt", pt_cnt[0] - cnt0, 2);
        chk("abort_no_more_s", s_cnt[0] - scnt0, 0);
        run_check(0, vecs[0].key, 10, vecs[0].lat, 1'b0);

        // reset pulse during KSA, then a run with en held high throughout
        load_vec(0);
        for (int b = 0; b < 10; b++) ct_src[0][b] = ct_buf[b];
        key_v[0] = vecs[0].key;
        en[0]    = 1'b1;
        @(negedge clk);
        en[0] = 1'b0;
        repeat (600) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_rdy", int'(rdy[0]), 1);
        chk("rst_mid_s_wren", int'(s_wren[0]), 0);
        scnt0 = s_cnt[0];
        cnt0  = pt_cnt[0];
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_no_s_write", s_cnt[0] - scnt0, 0);
        chk("rst_no_pt_write", pt_cnt[0] - cnt0, 0);
        run_check(0, vecs[0].key, 10, vecs[0].lat, 1'b1);
        @(negedge clk);
        chk("held_en_idle_after", int'(rdy[0]), 1);

        // randomized runs against the reference model
        for (int r = 0; r < 4; r++) begin
            rk  = $urandom & 32'h00FFFFFF;
            len = $urandom_range(0, 30);
            ct_buf[0] = 8'(len);
            for (int b = 1; b <= len; b++) ct_buf[b] = 8'($urandom);
            ref_model(rk, 3, 0, len + 1);
            run_check(0, rk, len + 1, 1538 + 6 * len, 1'b0);
        end

        rk  = $urandom;
        len = $urandom_range(1, 20);
        ct_buf[0] = 8'(len);
        for (int b = 1; b <= len; b++) ct_buf[b] = 8'($urandom);
        ref_model(rk, 4, 0, len + 1);
        run_check(1, rk, len + 1, 1538 + 6 * len, 1'b0);

        // maximum length: k runs up to 255
        rk = $urandom & 32'h00FFFFFF;
        ct_buf[0] = 8'd255;
        for (int b = 1; b < 256; b++) ct_buf[b] = 8'($urandom);
        ref_model(rk, 3, 0, 256);
        run_check(0, rk, 256, 1538 + 6 * 255, 1'b0);

        // RC4-drop768
        len = 12;
        ct_buf[0] = 8'(len);
        for (int b = 1; b <= len; b++) ct_buf[b] = 8'($urandom);
        ref_model(32'h004B6579, 3, 768, len + 1);
        run_check(2, 32'h004B6579, len + 1, 1538 + 6 * 768 + 6 * len, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
